// File: rtl/parity_rx4_pkg.sv
// Shared definitions for the serial parity receiver/transmitter pair:
// FSM encoding, line levels and frame length.
package parity_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  localparam int unsigned DEF_DATA_W = 4;

  // Start + data + parity + stop.
  function automatic int unsigned frame_len(input int unsigned data_w);
    return data_w + 3;
  endfunction

  localparam int unsigned DEF_FRAME_LEN = DEF_DATA_W + 3;

endpackage

// File: rtl/parity_rx4_if.sv
// Receiver-side bus: sample strobe and serial line in, received word and status out.
interface parity_rx4_if #(
  parameter int unsigned DATA_W = 4
);
  logic              bit_en;
  logic              sin;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  modport master (
    output bit_en, sin,
    input  rx_data, rx_valid, parity_err, frame_err, busy
  );

  modport slave (
    input  bit_en, sin,
    output rx_data, rx_valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/parity_rx4_calc.sv
// Combinational parity check: high when data plus parity bit disagree with the
// selected (even/odd) parity sense.
module parity_calc #(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic [DATA_W-1:0] data,
  input  logic              par,
  output logic              mismatch_c
);

  assign mismatch_c = (^data) ^ par ^ 1'(PARITY_ODD);

endmodule

// File: rtl/parity_rx4.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, parity, stop.
// Delivers every completed frame with parity/framing status flags.
module parity_rx4
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic         clk,
  input  logic         rstn,
  parity_rx4_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              par_q, par_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;
  logic              busy_q, busy_d;
  logic              mismatch_c;

  parity_calc #(
    .DATA_W     (DATA_W),
    .PARITY_ODD (PARITY_ODD)
  ) u_calc (
    .data       (shift_q),
    .par        (par_q),
    .mismatch_c (mismatch_c)
  );

  // Next-state, shift and status update; nothing moves without bit_en.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    par_d        = par_q;
    rx_data_d    = rx_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    rx_valid_d   = 1'b0;

    if (bus.bit_en) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.sin == START_LVL) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end
        end
        ST_DATA: begin
          // Right shift so the first (LSB) bit ends up in shift[0].
          shift_d = (shift_q >> 1) | (DATA_W'(bus.sin) << (DATA_W - 1));
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          par_d   = bus.sin;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          rx_data_d    = shift_q;
          parity_err_d = mismatch_c;
          frame_err_d  = (bus.sin != STOP_LVL);
          rx_valid_d   = 1'b1;
          state_d      = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      par_q        <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      par_q        <= par_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_parity_rx4.sv
// Directed bench for parity_rx4: even-parity and odd-parity receivers fed the
// same serial stream, results checked against hand-computed values.
module tb_parity_rx4;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_bad;

  parity_rx4_if #(.DATA_W(4)) ev_if ();
  parity_rx4_if #(.DATA_W(4)) od_if ();

  parity_rx4 #(.DATA_W(4), .PARITY_ODD(0)) u_ev (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ev_if)
  );

  parity_rx4 #(.DATA_W(4), .PARITY_ODD(1)) u_od (
    .clk  (clk),
    .rstn (rstn),
    .bus  (od_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One line bit: p-1 cycles without strobe, then one strobed cycle.
  task automatic bit_out(input logic b, input int p);
    ev_if.sin    = b;
    od_if.sin    = b;
    ev_if.bit_en = 1'b0;
    od_if.bit_en = 1'b0;
    repeat (p - 1) begin
      @(posedge clk); #1;
    end
    ev_if.bit_en = 1'b1;
    od_if.bit_en = 1'b1;
    @(posedge clk); #1;
    ev_if.bit_en = 1'b0;
    od_if.bit_en = 1'b0;
    ev_if.sin    = 1'b1;
    od_if.sin    = 1'b1;
  endtask

  task automatic idle(input int n);
    ev_if.bit_en = 1'b0;
    od_if.bit_en = 1'b0;
    ev_if.sin    = 1'b1;
    od_if.sin    = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [3:0] d, input logic par, input logic stp, input int p);
    bit_out(1'b0, p);
    check("busy_after_start", 32'(ev_if.busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      bit_out(d[i], p);
      check("no_early_valid", 32'(ev_if.rx_valid), 32'd0);
    end
    bit_out(par, p);
    check("no_valid_at_parity", 32'(ev_if.rx_valid), 32'd0);
    bit_out(stp, p);
  endtask

  // Called in the cycle right after the stop-bit edge.
  task automatic check_result(input string tag, input logic [3:0] d, input logic pe, input logic fe);
    check({tag, "_valid"}, 32'(ev_if.rx_valid), 32'd1);
    check({tag, "_data"}, 32'(ev_if.rx_data), 32'(d));
    check({tag, "_perr"}, 32'(ev_if.parity_err), 32'(pe));
    check({tag, "_ferr"}, 32'(ev_if.frame_err), 32'(fe));
    check({tag, "_busy"}, 32'(ev_if.busy), 32'd0);
    idle(1);
    check({tag, "_valid_drop"}, 32'(ev_if.rx_valid), 32'd0);
    check({tag, "_data_hold"}, 32'(ev_if.rx_data), 32'(d));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ev_data"}, 32'(ev_if.rx_data), 32'd0);
    check({tag, "_ev_valid"}, 32'(ev_if.rx_valid), 32'd0);
    check({tag, "_ev_perr"}, 32'(ev_if.parity_err), 32'd0);
    check({tag, "_ev_ferr"}, 32'(ev_if.frame_err), 32'd0);
    check({tag, "_ev_busy"}, 32'(ev_if.busy), 32'd0);
    check({tag, "_od_data"}, 32'(od_if.rx_data), 32'd0);
    check({tag, "_od_busy"}, 32'(od_if.busy), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rstn  = 1'b0;
    ev_if.bit_en = 1'b0;
    od_if.bit_en = 1'b0;
    ev_if.sin    = 1'b1;
    od_if.sin    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rstn = 1'b1;
    idle(2);

    // Data 0, parity 0, stop sampled low: framing error only.
    send_frame(4'h0, 1'b0, 1'b0, 1);
    check_result("ferr_frame", 4'h0, 1'b0, 1'b1);

    // Idle sample then 0xB with correct even parity.
    bit_out(1'b1, 1);
    check("idle_not_busy", 32'(ev_if.busy), 32'd0);
    send_frame(4'hB, 1'b1, 1'b1, 1);
    check_result("good_b", 4'hB, 1'b0, 1'b0);

    // Same word, wrong parity bit.
    send_frame(4'hB, 1'b0, 1'b1, 1);
    check_result("perr_b", 4'hB, 1'b1, 1'b0);

    // 0x6 with bit_en every 4th clock; outputs frozen mid-frame.
    bit_out(1'b0, 4);
    bit_out(1'b0, 4);
    bit_out(1'b1, 4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("slow_busy_hold", 32'(ev_if.busy), 32'd1);
      check("slow_data_hold", 32'(ev_if.rx_data), 32'hB);
      check("slow_perr_hold", 32'(ev_if.parity_err), 32'd1);
    end
    bit_out(1'b1, 4);
    bit_out(1'b0, 4);
    bit_out(1'b0, 4);
    check("slow_no_early_valid", 32'(ev_if.rx_valid), 32'd0);
    bit_out(1'b1, 4);
    check_result("slow_6", 4'h6, 1'b0, 1'b0);

    // Abort after two data bits with an asynchronous reset.
    bit_out(1'b0, 1);
    bit_out(1'b1, 1);
    bit_out(1'b1, 1);
    check("abort_busy", 32'(ev_if.busy), 32'd1);
    rstn = 1'b0;
    #1;
    check_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    check("midreset_valid", 32'(ev_if.rx_valid), 32'd0);
    rstn = 1'b1;
    bit_out(1'b1, 1);
    bit_out(1'b1, 1);
    check_zero("post_reset");
    send_frame(4'h3, 1'b0, 1'b1, 1);
    check_result("after_abort_3", 4'h3, 1'b0, 1'b0);

    // Odd vs even receivers on 0xF.
    send_frame(4'hF, 1'b1, 1'b1, 1);
    check("odd_f1_valid", 32'(od_if.rx_valid), 32'd1);
    check("odd_f1_data", 32'(od_if.rx_data), 32'hF);
    check("odd_f1_perr", 32'(od_if.parity_err), 32'd0);
    check("even_f1_perr", 32'(ev_if.parity_err), 32'd1);
    idle(1);
    send_frame(4'hF, 1'b0, 1'b1, 1);
    check("odd_f0_valid", 32'(od_if.rx_valid), 32'd1);
    check("odd_f0_perr", 32'(od_if.parity_err), 32'd1);
    check("odd_f0_ferr", 32'(od_if.frame_err), 32'd0);
    check("even_f0_perr", 32'(ev_if.parity_err), 32'd0);
    idle(2);
    check("final_odd_valid", 32'(od_if.rx_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/parity_rx4.md
Name: parity_rx4

Overview:
Serial receiver and parity checker for short data words. It deserialises a framed bit stream: start bit, DATA_W data bits LSB first, one parity bit, one stop bit. It checks the parity bit against an XOR reduction of the received data. It sits downstream of the serial parity transmitter and the XOR gate library, and presents each received word with status flags to the consuming logic.

Parameters:
- DATA_W, 4, data bits per frame (legal range 1..8).
- PARITY_ODD, 0, 0 = even parity (XOR of data and parity bit is 0); 1 = odd parity (that XOR is 1).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- bit_en  in  1  sample strobe (baud tick); sin is sampled only on clk edges where bit_en=1.
- sin  in  1  serial line; idles high.
- rx_data  out  DATA_W  last received word.
- rx_valid  out  1  one-cycle pulse marking a completed frame.
- parity_err  out  1  parity mismatch on the last frame.
- frame_err  out  1  stop bit sampled low on the last frame.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE, shift register=0, bit counter=0.
  - All outputs go to 0: rx_data, rx_valid, parity_err, frame_err, busy.
- States: IDLE, DATA, PARITY, STOP, encoded in 2 bits.
- bit_en=0: no state, counter or shift-register change; rx_valid still drops after its single cycle.
- IDLE:
  - On bit_en with sin=0 (start bit): go to DATA, clear the counter.
  - On bit_en with sin=1: stay in IDLE.
- DATA:
  - Each bit_en shifts sin in, LSB first: bit k lands in shift[k].
  - Counter increments on each bit_en.
  - After the DATA_W-th sample: go to PARITY.
- PARITY: on bit_en, latch sin as the parity bit, then go to STOP.
- STOP: on bit_en, on the same clock edge:
  - rx_data <= shift register.
  - parity_err <= (^shift ^ parity_bit) != PARITY_ODD.
  - frame_err <= ~sin.
  - rx_valid <= 1.
  - state <= IDLE.
- Latency: rx_valid is high for exactly the one clock cycle following the edge that samples the stop bit.
- Holding: rx_data, parity_err and frame_err hold until the next frame completes.
- Error frames: a frame with either error is still delivered with rx_valid=1; the consumer decides whether to discard it.
- busy = (state != IDLE), registered.
- Back-to-back frames: a start bit sampled on the first bit_en after STOP begins a new frame. The previous frame's outputs stay stable until the new stop bit.
- No glitch filtering: a start bit is accepted on a single low sample.
- Reset mid-frame: the frame is aborted, rx_valid is never asserted for it, and all outputs return to 0.
- bit_en held high every cycle is legal: one bit per clock, frame length DATA_W+3 cycles.

Decomposition:
- Shared package parity_pkg:
  - State encoding constants (ST_IDLE=0, ST_DATA=1, ST_PARITY=2, ST_STOP=3).
  - START_LVL=0, STOP_LVL=1, IDLE_LVL=1.
  - Frame length constant DATA_W+3, shared with the transmitter.
- One sub-module: parity_calc, a combinational XOR reduction of DATA_W data bits plus the parity bit, with output = mismatch given PARITY_ODD.
  - Instantiated once in the receiver.
  - Reused by the transmitter with the parity input tied to 0.

Test Plan:
- Even parity, bit_en always 1, sin sequence 1,0,1,1,0,1,1,1 (idle, start, data 1,1,0,1, parity 1, stop 1) -> rx_data=4'hB, rx_valid high one cycle at 7 clocks after the start sample, parity_err=0, frame_err=0, busy low afterwards.
- Same frame with parity bit 0 -> rx_data=4'hB, rx_valid=1, parity_err=1, frame_err=0.
- Data 4'h0, parity 0, stop bit 0 -> rx_valid=1, rx_data=4'h0, parity_err=0, frame_err=1.
- bit_en asserted every 4th clock, data 4'h6, parity 0 -> result identical to the contiguous case; state and rx_data unchanged on non-bit_en cycles.
- rstn pulsed low after the 2nd data bit, then a clean frame with 4'h3 -> no rx_valid for the aborted frame, outputs 0 during reset, second frame gives rx_data=4'h3 with no errors.
- PARITY_ODD=1, data 4'hF, parity 1 -> parity_err=0; same frame with parity 0 -> parity_err=1.
